// File: rtl/pip_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: register enables,
// bubble selects, PC enable, plus stall/flush performance counters.
module pip_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_ready,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  exe_redirect,
    input  logic                  exe_is_load,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    output logic                  pc_write_en,
    output logic                  fet_dec_write_en,
    output logic                  dec_exe_write_en,
    output logic                  exe_mem_write_en,
    output logic                  mem_wb_write_en,
    output logic                  fet_dec_bubble,
    output logic                  dec_exe_bubble,
    output logic                  mem_wb_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall, load_use, freeze, redirect_taken;
    logic pc_we, fd_we, de_we, em_we, mw_we, fd_bub, de_bub, mw_bub;

    assign mem_stall = dmem_req & ~dmem_ready;
    assign load_use  = exe_is_load & (exe_rd != '0) &
                       ((dec_rs1_used & (dec_rs1 == exe_rd)) |
                        (dec_rs2_used & (dec_rs2 == exe_rd)));

    // Once waiting on memory, only dmem_ready releases the freeze.
    assign freeze = (state_q == MEM_WAIT) ? ~dmem_ready : mem_stall;

    always_comb begin
        state_d        = state_q;
        pc_we          = 1'b1;
        fd_we          = 1'b1;
        de_we          = 1'b1;
        em_we          = 1'b1;
        mw_we          = 1'b1;
        fd_bub         = 1'b0;
        de_bub         = 1'b0;
        mw_bub         = 1'b0;
        redirect_taken = 1'b0;

        if (freeze) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            de_we  = 1'b0;
            em_we  = 1'b0;
            mw_bub = 1'b1;
            if (state_q == RUN) state_d = MEM_WAIT;
        end else if (state_q == DRAIN) begin
            // Whatever word arrives belongs to the squashed path: drop it.
            pc_we  = 1'b0;
            fd_bub = 1'b1;
            if (imem_ready) state_d = RUN;
        end else begin
            state_d = RUN;
            if (exe_redirect) begin
                redirect_taken = 1'b1;
                fd_bub         = 1'b1;
                de_bub         = 1'b1;
                // A fetch still in flight would return a wrong-path word.
                if (!imem_ready) state_d = DRAIN;
            end else if (load_use) begin
                pc_we  = 1'b0;
                fd_we  = 1'b0;
                de_bub = 1'b1;
            end else if (!imem_ready) begin
                pc_we  = 1'b0;
                fd_bub = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_we};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, redirect_taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // EXE holds a bubble while draining, so a redirect here means upstream is broken.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == DRAIN) assert (!exe_redirect);
    end

    assign pc_write_en      = rst_n & pc_we;
    assign fet_dec_write_en = rst_n & fd_we;
    assign dec_exe_write_en = rst_n & de_we;
    assign exe_mem_write_en = rst_n & em_we;
    assign mem_wb_write_en  = rst_n & mw_we;
    assign fet_dec_bubble   = rst_n & fd_bub;
    assign dec_exe_bubble   = rst_n & de_bub;
    assign mem_wb_bubble    = rst_n & mw_bub;
    assign stall_cnt        = stall_cnt_q;
    assign flush_cnt        = flush_cnt_q;

endmodule

// File: tb/tb_pip_ctrl.sv
// Scoreboard bench for pip_ctrl: stimulus pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pip_ctrl;

    localparam int RW = 5;
    localparam int CW = 8;

    // Output vector order: {pc, fet_dec, dec_exe, exe_mem, mem_wb, fd_bub, de_bub, mw_bub}
    localparam logic [7:0] A_RESET  = 8'b0000_0000;
    localparam logic [7:0] A_NORMAL = 8'b1111_1000;
    localparam logic [7:0] A_FREEZE = 8'b0000_1001;
    localparam logic [7:0] A_REDIR  = 8'b1111_1110;
    localparam logic [7:0] A_LDUSE  = 8'b0011_1010;
    localparam logic [7:0] A_FETCHW = 8'b0111_1100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic imem_ready = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, exe_redirect = 1'b0;
    logic exe_is_load = 1'b0, dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
    logic [RW-1:0] exe_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic pc_write_en, fet_dec_write_en, dec_exe_write_en, exe_mem_write_en, mem_wb_write_en;
    logic fet_dec_bubble, dec_exe_bubble, mem_wb_bubble;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pip_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .exe_redirect(exe_redirect), .exe_is_load(exe_is_load), .exe_rd(exe_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .pc_write_en(pc_write_en), .fet_dec_write_en(fet_dec_write_en),
        .dec_exe_write_en(dec_exe_write_en), .exe_mem_write_en(exe_mem_write_en),
        .mem_wb_write_en(mem_wb_write_en), .fet_dec_bubble(fet_dec_bubble),
        .dec_exe_bubble(dec_exe_bubble), .mem_wb_bubble(mem_wb_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: mode 0 = running, 1 = waiting on data memory, 2 = discarding stale fetch
    int          mode = 0;
    int unsigned m_stall = 0, m_flush = 0;

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            mode = 0; m_stall = 0; m_flush = 0;
            q.push_back('{ctl: A_RESET, sc: '0, fc: '0});
        end
    endtask

    task automatic issue(input logic im, input logic dq, input logic dr, input logic rdr,
                         input logic ld, input logic [RW-1:0] erd,
                         input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                         input logic u1, input logic u2);
        logic [7:0] act;
        logic       lu, waiting;
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = im; dmem_req = dq; dmem_ready = dr; exe_redirect = rdr;
        exe_is_load = ld; exe_rd = erd; dec_rs1 = r1; dec_rs2 = r2;
        dec_rs1_used = u1; dec_rs2_used = u2;

        lu = ld && (erd != 0) && ((u1 && r1 == erd) || (u2 && r2 == erd));
        waiting = (mode == 1) ? !dr : (dq && !dr);
        if (waiting) begin
            act = A_FREEZE;
            if (mode == 0) mode = 1;
        end else if (mode == 2) begin
            act = A_FETCHW;
            if (im) mode = 0;
        end else begin
            mode = 0;
            if (rdr) begin
                act = A_REDIR;
                if (!im) mode = 2;
            end else if (lu)  act = A_LDUSE;
            else if (!im)     act = A_FETCHW;
            else              act = A_NORMAL;
        end
        q.push_back('{ctl: act, sc: CW'(m_stall), fc: CW'(m_flush)});
        if (act[7] == 1'b0) m_stall++;
        if (act == A_REDIR) m_flush++;
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++) issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {pc_write_en, fet_dec_write_en, dec_exe_write_en, exe_mem_write_en,
                       mem_wb_write_en, fet_dec_bubble, dec_exe_bubble, mem_wb_bubble};
                n_chk++;
                if (got !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl @%0t: got %b required %b", $time, got, e.ctl);
                end
                n_chk++;
                if (stall_cnt !== e.sc) begin
                    n_fail++;
                    $display("FAIL stall_cnt @%0t: got %0d required %0d", $time, stall_cnt, e.sc);
                end
                n_chk++;
                if (flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL flush_cnt @%0t: got %0d required %0d", $time, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        do_reset(2);
        normal(10);

        // load-use on rs2
        issue(1, 0, 0, 0, 1, 5, 0, 5, 0, 1);
        normal(2);

        // memory wait with a redirect held in EXE throughout
        repeat (3) issue(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        normal(2);

        // redirect with fetch outstanding, then drain
        issue(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        normal(2);

        // load-use and redirect together: redirect wins
        issue(1, 0, 0, 1, 1, 3, 3, 0, 1, 0);
        normal(2);

        // rd = x0 never hazards
        issue(1, 0, 0, 0, 1, 0, 0, 0, 1, 1);

        // long fetch stall wraps the counter
        for (int i = 0; i < 260; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        normal(3);

        // reset in the middle of a memory wait
        issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(2);
        normal(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rd_r;
            rd_r = ($urandom_range(0, 99) < 15) && (mode != 2);
            issue($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 1), rd_r, $urandom_range(0, 1),
                  RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
